ila_capture_ctrl: RTL and testbench
===================================

ILA_CAPTURE_CTRL -- requirements
Module: ila_capture_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_W, default 10, capture buffer address width; depth D = 2^BUFFER_W.
REQ-002 SHALL have port clk_i, input, 1, the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port cke_i, input, 1, clock enable; when low, all state holds and buf_wen_o=0.
REQ-005 SHALL have port arm_i, input, 1, one-cycle pulse that starts a capture.
REQ-006 SHALL have port abort_i, input, 1, one-cycle pulse that cancels a capture.
REQ-007 SHALL have port pretrig_i, input, BUFFER_W, number of pre-trigger samples required before the trigger is accepted.
REQ-008 SHALL have port posttrig_i, input, BUFFER_W, number of samples written after the trigger sample.
REQ-009 SHALL have port sample_valid_i, input, 1, a sample is present this cycle.
REQ-010 SHALL have port trigger_i, input, 1, the reduced trigger, qualified by sample_valid_i.
REQ-011 SHALL have port buf_wen_o, output, 1, buffer write enable.
REQ-012 SHALL have port buf_waddr_o, output, BUFFER_W, buffer write address.
REQ-013 SHALL have port state_o, output, 3, current state encoding.
REQ-014 SHALL have port done_o, output, 1, capture complete.
REQ-015 SHALL have port trig_addr_o, output, BUFFER_W, address of the trigger sample.
REQ-016 SHALL have port start_addr_o, output, BUFFER_W, address of the oldest valid sample.
REQ-017 SHALL have port n_samples_o, output, BUFFER_W+1, number of valid samples, saturating at D.

Function
REQ-018 SHALL implement the states IDLE=0, PRE=1, ARMED=2, TRIG=3 and DONE=4, and state_o SHALL equal the state register.
REQ-019 SHALL latch pretrig_i and posttrig_i on the arm_i cycle, so later changes to them are ignored until the next arm.
REQ-020 On arm_i in IDLE or DONE, SHALL clear the write pointer, n_samples and done, and enter PRE on the next cycle.
REQ-021 SHALL ignore arm_i in PRE, ARMED and TRIG.
REQ-022 In PRE, ARMED and TRIG, SHALL drive buf_wen_o = sample_valid_i & cke_i combinationally.
REQ-023 SHALL drive buf_waddr_o from the registered write pointer.
REQ-024 On each write, the write pointer SHALL increment and wrap modulo D, and n_samples SHALL increment, saturating at D.
REQ-025 In PRE, SHALL ignore trigger_i and move to ARMED when n_samples (after the update) is at least the latched pretrig.
REQ-026 A latched pretrig of 0 SHALL make PRE last one cycle.
REQ-027 In ARMED, on sample_valid_i & trigger_i, that sample SHALL be written and trig_addr SHALL be set to its address.
REQ-028 Following REQ-027, the state SHALL go to TRIG with the remaining count set to the latched posttrig, or go straight to DONE if the latched posttrig is 0.
REQ-029 In TRIG, each write SHALL decrement the remaining count, and the write that takes it to 0 SHALL be the last write before entering DONE.
REQ-030 In DONE, SHALL hold buf_wen_o=0 and done_o=1, and all addresses SHALL hold.
REQ-031 start_addr_o SHALL be 0 if n_samples < D, and the write pointer otherwise, meaning the oldest sample has already been overwritten.
REQ-032 If pretrig+posttrig+1 > D, the oldest pre-trigger samples SHALL be overwritten; no error is flagged.
REQ-033 abort_i SHALL force IDLE on the next cycle from any state.
REQ-034 In the abort_i cycle, buf_wen_o SHALL be 0 and done_o SHALL clear.
REQ-035 When arm_i and abort_i are asserted in the same cycle, abort_i SHALL win.
REQ-036 On abort_i, n_samples_o and trig_addr_o SHALL hold their values until the next arm.

Reset
REQ-037 rst_i SHALL take priority over cke_i, arm_i and abort_i.
REQ-038 rst_i SHALL force state IDLE and set all registers and outputs to 0 on the next edge, including when asserted mid-capture.

Verification (BUFFER_W=4, D=16)
REQ-039 Reset: after rst_i for 1 cycle -> state_o=0, buf_wen_o=0, done_o=0, n_samples_o=0, trig_addr_o=0, start_addr_o=0.
REQ-040 Basic capture: pretrig=3, posttrig=4, arm, then sample_valid_i=1 and trigger_i=1 every cycle -> writes at addresses 0..7, trig_addr_o=3, done_o rises after the write to address 7, n_samples_o=8, start_addr_o=0.
REQ-041 Wrap: pretrig=5, posttrig=2, trigger raised first on the 20th valid sample -> trig_addr_o=3, last writes to addresses 4 and 5, n_samples_o=16, start_addr_o=6.
REQ-042 posttrig=0: pretrig=2, trigger on the 3rd sample -> ARMED goes straight to DONE, last write at address 2, trig_addr_o=2.
REQ-043 Abort in TRIG: abort after 1 post-trigger write -> buf_wen_o=0 in that cycle, state_o=0 on the next cycle, done_o=0, later sample_valid_i causes no writes.
REQ-044 Priority: from DONE, arm_i and abort_i asserted together -> IDLE; separately, cke_i=0 with sample_valid_i=1 -> no write and the pointer is unchanged.

Source files
------------

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: write-side controller for a logic analyser capture buffer.
// It fills a circular buffer with pre-trigger history and arms the trigger once
// enough history exists. It records where the trigger landed and stops after
// the requested post-trigger samples. It also reports which region of the
// buffer holds valid data.
module ila_capture_ctrl #(
  parameter int BUFFER_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] pretrig_i,
  input  logic [BUFFER_W-1:0] posttrig_i,
  input  logic                sample_valid_i,
  input  logic                trigger_i,
  output logic                buf_wen_o,
  output logic [BUFFER_W-1:0] buf_waddr_o,
  output logic [2:0]          state_o,
  output logic                done_o,
  output logic [BUFFER_W-1:0] trig_addr_o,
  output logic [BUFFER_W-1:0] start_addr_o,
  output logic [BUFFER_W:0]   n_samples_o
);

  // Buffer depth, one bit wider than an address so the full count fits.
  localparam logic [BUFFER_W:0] DEPTH = {1'b1, {BUFFER_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_TRIG  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [BUFFER_W-1:0] r_wptr;
  logic [BUFFER_W:0]   r_nsamp;
  logic                r_done;
  logic [BUFFER_W-1:0] r_trig_addr;
  logic [BUFFER_W-1:0] r_pre;
  logic [BUFFER_W-1:0] r_post;
  logic [BUFFER_W-1:0] r_remain;

  logic                w_capturing;
  logic                w_wen;
  logic [BUFFER_W:0]   w_nsamp_inc;
  logic [BUFFER_W:0]   w_nsamp_upd;
  logic                w_trig_hit;
  logic                w_last_post;
  logic                w_arm_accept;

  // Next-state logic plus the write strobe and capture events feeding the datapath.
  always_comb begin
    w_state_next = r_state;
    w_capturing  = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_TRIG);
    // An abort or reset cycle never writes, even while capturing.
    w_wen        = w_capturing & sample_valid_i & cke_i & ~abort_i & ~rst_i;
    w_nsamp_inc  = (r_nsamp == DEPTH) ? r_nsamp : r_nsamp + (BUFFER_W + 1)'(1);
    w_nsamp_upd  = w_wen ? w_nsamp_inc : r_nsamp;
    w_trig_hit   = w_wen & trigger_i & (r_state == S_ARMED);
    w_last_post  = w_wen & (r_state == S_TRIG) & (r_remain == BUFFER_W'(1));
    w_arm_accept = cke_i & ~abort_i & arm_i & ((r_state == S_IDLE) || (r_state == S_DONE));

    if (cke_i) begin
      if (abort_i) begin
        w_state_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: if (arm_i) w_state_next = S_PRE;
          // Compare against the count including this cycle's write; a zero
          // pretrig therefore leaves PRE after a single cycle.
          S_PRE:   if (w_nsamp_upd >= {1'b0, r_pre}) w_state_next = S_ARMED;
          S_ARMED: if (w_trig_hit) w_state_next = (r_post == '0) ? S_DONE : S_TRIG;
          S_TRIG:  if (w_last_post) w_state_next = S_DONE;
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Write pointer, sample count, trigger address and latched capture settings.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_nsamp     <= '0;
      r_done      <= 1'b0;
      r_trig_addr <= '0;
      r_pre       <= '0;
      r_post      <= '0;
      r_remain    <= '0;
    end else if (cke_i) begin
      // done simply mirrors "the next state is DONE"; abort and arm both leave it low.
      r_done <= (w_state_next == S_DONE);
      if (abort_i) begin
        // Pointer, count and trigger address stay visible for readout.
      end else if (w_arm_accept) begin
        r_wptr      <= '0;
        r_nsamp     <= '0;
        r_trig_addr <= '0;
        r_pre       <= pretrig_i;
        r_post      <= posttrig_i;
        r_remain    <= '0;
      end else begin
        if (w_wen) begin
          r_wptr  <= r_wptr + BUFFER_W'(1);
          r_nsamp <= w_nsamp_inc;
        end
        if (w_trig_hit) begin
          r_trig_addr <= r_wptr;
          r_remain    <= r_post;
        end else if (w_wen && (r_state == S_TRIG)) begin
          r_remain <= r_remain - BUFFER_W'(1);
        end
      end
    end
  end

  assign buf_wen_o    = w_wen;
  assign buf_waddr_o  = r_wptr;
  assign state_o      = r_state;
  assign done_o       = r_done;
  assign trig_addr_o  = r_trig_addr;
  assign n_samples_o  = r_nsamp;
  // Once the buffer has filled, the next slot to be written holds the oldest sample.
  assign start_addr_o = r_nsamp[BUFFER_W] ? r_wptr : '0;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Testbench for ila_capture_ctrl (BUFFER_W=4, D=16): directed scenarios then
// random traffic, all checked cycle by cycle against a behavioural model.
module tb_ila_capture_ctrl;
  localparam int W = 4;
  localparam int D = 16;

  logic         clk_i = 1'b0;
  logic         rst_i, cke_i, arm_i, abort_i, sample_valid_i, trigger_i;
  logic [W-1:0] pretrig_i, posttrig_i;
  logic         buf_wen_o, done_o;
  logic [W-1:0] buf_waddr_o, trig_addr_o, start_addr_o;
  logic [2:0]   state_o;
  logic [W:0]   n_samples_o;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a capture is a count of writes since arm.
  // The address is that count mod D; the valid sample count saturates at D.
  int m_state, m_total, m_pre, m_post, m_left, m_trig, m_done;

  ila_capture_ctrl #(.BUFFER_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i), .arm_i(arm_i), .abort_i(abort_i),
    .pretrig_i(pretrig_i), .posttrig_i(posttrig_i), .sample_valid_i(sample_valid_i),
    .trigger_i(trigger_i), .buf_wen_o(buf_wen_o), .buf_waddr_o(buf_waddr_o),
    .state_o(state_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
    .start_addr_o(start_addr_o), .n_samples_o(n_samples_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nsat(input int total);
    return (total >= D) ? D : total;
  endfunction

  function automatic bit exp_wen();
    return (m_state >= 1 && m_state <= 3) && sample_valid_i && cke_i && !abort_i && !rst_i;
  endfunction

  task automatic check_outputs();
    chk("state", 32'(state_o), 32'(m_state));
    chk("wen", 32'(buf_wen_o), 32'(exp_wen()));
    chk("waddr", 32'(buf_waddr_o), 32'(m_total % D));
    chk("done", 32'(done_o), 32'(m_done));
    chk("n_samples", 32'(n_samples_o), 32'(nsat(m_total)));
    chk("trig_addr", 32'(trig_addr_o), 32'(m_trig));
    chk("start_addr", 32'(start_addr_o), 32'((m_total >= D) ? (m_total % D) : 0));
  endtask

  task automatic model_update();
    bit wr;
    wr = exp_wen();
    if (rst_i) begin
      m_state = 0; m_total = 0; m_pre = 0; m_post = 0; m_left = 0; m_trig = 0; m_done = 0;
    end else if (cke_i) begin
      if (abort_i) begin
        m_state = 0; m_done = 0;
      end else begin
        case (m_state)
          0, 4: if (arm_i) begin
            m_state = 1; m_total = 0; m_done = 0; m_trig = 0;
            m_pre = int'(pretrig_i); m_post = int'(posttrig_i);
          end
          1: begin
            if (wr) m_total++;
            if (nsat(m_total) >= m_pre) m_state = 2;
          end
          2: if (wr) begin
            if (trigger_i) begin
              m_trig = m_total % D;
              if (m_post == 0) begin m_state = 4; m_done = 1; end
              else begin m_state = 3; m_left = m_post; end
            end
            m_total++;
          end
          3: if (wr) begin
            m_total++;
            m_left--;
            if (m_left == 0) begin m_state = 4; m_done = 1; end
          end
          default: m_state = 0;
        endcase
      end
    end
  endtask

  // One clock cycle: drive, settle, check against the model, advance the model.
  task automatic step(input logic arm, input logic abort, input logic valid,
                      input logic trg, input logic cke, input logic rst);
    arm_i = arm; abort_i = abort; sample_valid_i = valid;
    trigger_i = trg; cke_i = cke; rst_i = rst;
    #4;
    if (!rst) check_outputs();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    pretrig_i = '0; posttrig_i = '0;
    m_state = 0; m_total = 0; m_pre = 0; m_post = 0; m_left = 0; m_trig = 0; m_done = 0;
    arm_i = 0; abort_i = 0; sample_valid_i = 0; trigger_i = 0; cke_i = 1; rst_i = 1;
    @(posedge clk_i);
    #1;

    // Reset values.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_nsamp", 32'(n_samples_o), 0);
    chk("rst_done", 32'(done_o), 0);

    // Basic capture: pretrig 3, posttrig 4, trigger held high.
    pretrig_i = 4'd3; posttrig_i = 4'd4;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pretrig_i = 4'd9; posttrig_i = 4'd1;   // changes after arm must be ignored
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("basic_done", 32'(done_o), 1);
    chk("basic_trig", 32'(trig_addr_o), 3);
    chk("basic_nsamp", 32'(n_samples_o), 8);
    chk("basic_start", 32'(start_addr_o), 0);

    // Wrap: pretrig 5, posttrig 2, first trigger on the 20th valid sample.
    pretrig_i = 4'd5; posttrig_i = 4'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("wrap_trig", 32'(trig_addr_o), 3);
    chk("wrap_nsamp", 32'(n_samples_o), 16);
    chk("wrap_start", 32'(start_addr_o), 6);
    chk("wrap_state", 32'(state_o), 4);

    // posttrig 0: ARMED goes straight to DONE.
    pretrig_i = 4'd2; posttrig_i = 4'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pt0_trig", 32'(trig_addr_o), 2);
    chk("pt0_waddr", 32'(buf_waddr_o), 3);
    chk("pt0_state", 32'(state_o), 4);

    // Abort in TRIG after one post-trigger write.
    pretrig_i = 4'd1; posttrig_i = 4'd5;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_state", 32'(state_o), 0);
    chk("abort_done", 32'(done_o), 0);
    chk("abort_trig", 32'(trig_addr_o), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Priority: arm with abort from DONE, then clock enable low.
    pretrig_i = 4'd0; posttrig_i = 4'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_done_state", 32'(state_o), 4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("prio_abort_state", 32'(state_o), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cke_waddr", 32'(buf_waddr_o), 0);

    // Mid-capture reset.
    pretrig_i = 4'd6; posttrig_i = 4'd3;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("midrst_waddr", 32'(buf_waddr_o), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      pretrig_i  = W'($urandom_range(0, D - 1));
      posttrig_i = W'($urandom_range(0, D - 1));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
